// File: rtl/sdram_req_queue_pkg.sv
// sdram_req_queue_pkg: shared FSM encodings and default address width for the SDRAM request queue.
// HADDR_WIDTH_DEF must match the controller's host address width.
package sdram_req_queue_pkg;
    localparam int HADDR_WIDTH_DEF = 25;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ACTIVE = 2'd2
    } state_e;
endpackage

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: synchronous request FIFO with full/empty flags and an occupancy count.
// The level carries one extra bit so a full FIFO is distinguishable from an empty one.
module sdram_req_fifo #(
    parameter int WIDTH      = 34,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(push_i) - LW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = level_q == LW'(DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
endmodule

// File: rtl/sdram_req_queue.sv
// sdram_req_queue: buffers host byte requests and issues them one at a time to the SDRAM controller.
// Defining SDRAM_REQ_TIMEOUT_EN adds a watchdog that aborts stuck accesses and raises sticky err_timeout.
module sdram_req_queue
    import sdram_req_queue_pkg::*;
#(
    parameter int HADDR_WIDTH     = HADDR_WIDTH_DEF,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [HADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]               req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_rdata,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic [HADDR_WIDTH-1:0]   sd_wr_addr,
    output logic [HADDR_WIDTH-1:0]   sd_rd_addr,
    output logic [7:0]               sd_wr_data,
    output logic                     sd_wr_enable,
    output logic                     sd_rd_enable,
    input  logic [7:0]               sd_rd_data,
    input  logic                     sd_rd_ready,
    input  logic                     sd_busy
`ifdef SDRAM_REQ_TIMEOUT_EN
    ,
    output logic                     err_timeout
`endif
);
    localparam int EW = HADDR_WIDTH + 9;

    logic                   push, pop, full, empty, head_we;
    logic [EW-1:0]          head;
    logic [HADDR_WIDTH-1:0] head_addr;
    logic [7:0]             head_data;
    state_e                 state_q, state_d;
    logic                   wr_en_q, wr_en_d, rd_en_q, rd_en_d, cur_we_q, cur_we_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [7:0]             rsp_rdata_q, rsp_rdata_d;

    assign push      = req_valid && !full;
    assign req_ready = !full;
    assign {head_we, head_addr, head_data} = head;

    sdram_req_fifo #(.WIDTH(EW), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({req_we, req_addr, req_wdata}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

`ifdef SDRAM_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, timeout;
    assign timeout     = state_q != IDLE && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign err_timeout = err_q;
`endif

    always_comb begin
        state_d     = state_q;
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        cur_we_d    = cur_we_q;
        pop         = 1'b0;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: if (!empty && (head_we || !rsp_valid_q) && !sd_busy) begin
                state_d = ISSUE;
                wr_en_d = head_we;
                rd_en_d = !head_we;
            end
            // controller only samples enables while idle, so holding them until busy is safe
            ISSUE: if (sd_busy) begin
                state_d  = ACTIVE;
                wr_en_d  = 1'b0;
                rd_en_d  = 1'b0;
                cur_we_d = head_we;
                pop      = 1'b1;
            end
            ACTIVE: begin
                if (sd_rd_ready && !cur_we_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = sd_rd_data;
                end
                if (!sd_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef SDRAM_REQ_TIMEOUT_EN
        err_d = err_q;
        if (timeout) begin
            err_d   = 1'b1;
            wr_en_d = 1'b0;
            rd_en_d = 1'b0;
            state_d = IDLE;
            if (state_q == ISSUE) pop = 1'b1;
        end
        cnt_d = (state_d == IDLE) ? '0 : cnt_q + 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            cur_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            cur_we_q    <= cur_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef SDRAM_REQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign sd_wr_addr   = head_addr;
    assign sd_rd_addr   = head_addr;
    assign sd_wr_data   = head_data;
    assign sd_wr_enable = wr_en_q;
    assign sd_rd_enable = rd_en_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
endmodule
